// File: rtl/canny_seq.sv
// canny_seq: sequencer for the 5x5 Canny edge datapath engine.
// Fetches the planes the selected mode needs from a pixel source, writes them
// into the engine, clears and runs the engine for a fixed per-mode cycle
// count, reads the result(s) back and reports them on a valid/tag interface.
// Optional feature macro: CANNY_SEQ_PERF_EN (busy-cycle counter on
// perf_cycles; without it the port is tied to zero).
module canny_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int GAUSS_CYC  = 3,
  parameter int SOBEL_CYC  = 5,
  parameter int NMS_CYC    = 3,
  parameter int HYST_CYC   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic [2:0]            result_sel,
  output logic                  src_req,
  output logic [1:0]            src_plane,
  output logic [2:0]            src_row,
  output logic [2:0]            src_col,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic [2:0]            eng_row,
  output logic [2:0]            eng_col,
  output logic                  eng_bCE,
  output logic                  eng_bWE,
  output logic [DATA_WIDTH-1:0] eng_InData,
  output logic [2:0]            eng_OPMode,
  output logic                  eng_bOPEnable,
  output logic [3:0]            eng_dReadReg,
  output logic [3:0]            eng_dWriteReg,
  input  logic [DATA_WIDTH-1:0] eng_OutData,
  output logic [15:0]           perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CLEAR   = 3'd2,
    S_EXEC    = 3'd3,
    S_READ    = 3'd4,
    S_CAPTURE = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]            mode_reg;
  logic [1:0]            fetch_plane_reg;
  logic [2:0]            fetch_row_reg;
  logic [2:0]            fetch_col_reg;
  logic                  fetch_done_reg;
  logic                  wr_en_reg;
  logic [1:0]            wr_plane_reg;
  logic [2:0]            wr_row_reg;
  logic [2:0]            wr_col_reg;
  logic [7:0]            exec_cnt_reg;
  logic                  second_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic [2:0]            sel_reg;

  logic                  accept;
  logic                  bad_start;
  logic                  fetch_last;
  logic                  final_beat;
  logic [1:0]            last_plane;
  logic [7:0]            exec_load;
  logic [2:0]            read_code;

  // A valid start is taken only from IDLE; modes 4-7 divert to the error path.
  assign accept    = (state_reg == S_IDLE) && start && !mode[2];
  assign bad_start = (state_reg == S_IDLE) && start && mode[2];

  // Per-mode plane count, run length and dReadReg code of the current beat.
  always_comb begin
    last_plane = 2'd0;
    exec_load  = 8'(GAUSS_CYC - 1);
    read_code  = 3'd0;
    case (mode_reg)
      3'd1: begin
        exec_load = 8'(SOBEL_CYC - 1);
        read_code = second_reg ? 3'd2 : 3'd1;
      end
      3'd2: begin
        last_plane = 2'd1;
        exec_load  = 8'(NMS_CYC - 1);
        read_code  = 3'd3;
      end
      3'd3: begin
        last_plane = 2'd2;
        exec_load  = 8'(HYST_CYC - 1);
        read_code  = 3'd4;
      end
      default: ;
    endcase
  end

  assign fetch_last = (fetch_plane_reg == last_plane) && (fetch_row_reg == 3'd4) &&
                      (fetch_col_reg == 3'd4);
  // Sobel yields a gradient beat followed by a direction beat.
  assign final_beat = !((mode_reg == 3'd1) && !second_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept)         state_next = S_LOAD;
        else if (bad_start) state_next = S_ERR;
      end
      S_LOAD:    if (fetch_done_reg) state_next = S_CLEAR;
      S_CLEAR:   state_next = S_EXEC;
      S_EXEC:    if (exec_cnt_reg == 8'd0) state_next = S_READ;
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = final_beat ? S_IDLE : S_READ;
      S_ERR:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode; engine write pins follow the one-cycle-delayed fetch.
  always_comb begin
    busy          = (state_reg != S_IDLE);
    done          = ((state_reg == S_CAPTURE) && final_beat) || (state_reg == S_ERR);
    err           = (state_reg == S_ERR);
    result_valid  = (state_reg == S_CAPTURE);
    result        = (state_reg == S_CAPTURE) ? eng_OutData : result_reg;
    result_sel    = (state_reg == S_CAPTURE) ? read_code : sel_reg;
    src_req       = (state_reg == S_LOAD) && !fetch_done_reg;
    src_plane     = fetch_plane_reg;
    src_row       = fetch_row_reg;
    src_col       = fetch_col_reg;
    eng_bCE       = !(wr_en_reg || (state_reg == S_READ));
    eng_bWE       = !wr_en_reg;
    eng_InData    = wr_en_reg ? src_data : '0;
    eng_OPMode    = (state_reg == S_EXEC) ? mode_reg : 3'd0;
    eng_bOPEnable = (state_reg != S_EXEC);
    eng_dReadReg  = (state_reg == S_READ) ? {1'b0, read_code} : 4'd0;
    eng_dWriteReg = wr_en_reg ? {2'b00, wr_plane_reg} : 4'd0;
    eng_row       = 3'd0;
    eng_col       = 3'd0;
    if (wr_en_reg) begin
      eng_row = wr_row_reg;
      eng_col = wr_col_reg;
    end else if ((state_reg == S_READ) && (mode_reg == 3'd2)) begin
      eng_row = 3'd1;
      eng_col = 3'd1;
    end
  end

  // Fetch address walk, write delay line, run counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg        <= 3'd0;
      fetch_plane_reg <= 2'd0;
      fetch_row_reg   <= 3'd0;
      fetch_col_reg   <= 3'd0;
      fetch_done_reg  <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_plane_reg    <= 2'd0;
      wr_row_reg      <= 3'd0;
      wr_col_reg      <= 3'd0;
      exec_cnt_reg    <= 8'd0;
      second_reg      <= 1'b0;
      result_reg      <= '0;
      sel_reg         <= 3'd0;
    end else begin
      // Source data arrives one cycle after the request, so the write
      // address/plane are delayed by one cycle to line up with it.
      wr_en_reg    <= src_req;
      wr_plane_reg <= fetch_plane_reg;
      wr_row_reg   <= fetch_row_reg;
      wr_col_reg   <= fetch_col_reg;

      if (accept) begin
        mode_reg        <= mode;
        fetch_plane_reg <= 2'd0;
        fetch_row_reg   <= 3'd0;
        fetch_col_reg   <= 3'd0;
        fetch_done_reg  <= 1'b0;
        second_reg      <= 1'b0;
      end else if (src_req) begin
        if (fetch_last) begin
          fetch_done_reg <= 1'b1;
        end else if (fetch_col_reg == 3'd4) begin
          fetch_col_reg <= 3'd0;
          if (fetch_row_reg == 3'd4) begin
            fetch_row_reg   <= 3'd0;
            fetch_plane_reg <= fetch_plane_reg + 2'd1;
          end else begin
            fetch_row_reg <= fetch_row_reg + 3'd1;
          end
        end else begin
          fetch_col_reg <= fetch_col_reg + 3'd1;
        end
      end

      if (state_reg == S_CLEAR) begin
        exec_cnt_reg <= exec_load;
      end else if ((state_reg == S_EXEC) && (exec_cnt_reg != 8'd0)) begin
        exec_cnt_reg <= exec_cnt_reg - 8'd1;
      end

      if (state_reg == S_CAPTURE) begin
        result_reg <= eng_OutData;
        sel_reg    <= read_code;
        second_reg <= 1'b1;
      end
    end
  end

`ifdef CANNY_SEQ_PERF_EN
  logic        start_taken;
  logic [15:0] perf_reg;

  assign start_taken = (state_reg == S_IDLE) && start;

  // Busy-cycle counter: clears on accept, saturates, holds after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= 16'd0;
    end else if (start_taken) begin
      perf_reg <= 16'd0;
    end else if (busy && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: doc/canny_seq.md
Name: canny_seq

Overview:
- Sequencer for the 5x5 Canny edge datapath engine.
- On `start`, it fetches the planes the selected mode needs (X, Y, Z) from a pixel-source read port and writes them into the engine through its `bCE`/`bWE` write port.
- It then clears and runs the engine for a fixed per-mode cycle count, reads back the result(s) and reports them on a valid/tag interface.
- It sits between the image-buffer control and the engine, so no higher-level block touches engine handshake pins directly.

Parameters:
- DATA_WIDTH, 8: pixel and result width.
- GAUSS_CYC, 3: cycles `eng_bOPEnable` is held low in Gaussian mode.
- SOBEL_CYC, 5: cycles `eng_bOPEnable` is held low in Sobel mode.
- NMS_CYC, 3: cycles `eng_bOPEnable` is held low in NMS mode.
- HYST_CYC, 3: cycles `eng_bOPEnable` is held low in Hysteresis mode.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  3  0 Gaussian, 1 Sobel, 2 NMS, 3 Hysteresis; 4-7 invalid.
- busy  out  1  high from start-accept until the done cycle inclusive.
- done  out  1  one-cycle pulse at end of operation.
- err  out  1  qualifies `done`: invalid mode.
- result  out  DATA_WIDTH  captured engine output.
- result_valid  out  1  one-cycle pulse per result beat.
- result_sel  out  3  dReadReg code of the beat: 0 gf, 1 gradient, 2 direction, 3 NMS, 4 hysteresis.
- src_req  out  1  pixel-source read strobe.
- src_plane  out  2  0 X, 1 Y, 2 Z.
- src_row, src_col  out  3 each  pixel coordinate, 0..4.
- src_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after `src_req`.
- eng_row, eng_col  out  3 each  engine dAddrRegRow/dAddrRegCol.
- eng_bCE, eng_bWE  out  1 each  engine chip/write enables, active-low.
- eng_InData  out  DATA_WIDTH  engine write data.
- eng_OPMode  out  3  engine OPMode.
- eng_bOPEnable  out  1  engine op enable, active-low.
- eng_dReadReg, eng_dWriteReg  out  4 each  engine read/write register selects.
- eng_OutData  in  DATA_WIDTH  engine read data; updates on the edge ending a read cycle.

Behaviour:
- Reset values: `busy`, `done`, `err`, `result_valid`, `src_req` = 0; `result`, `result_sel`, `src_*`, `eng_row`, `eng_col`, `eng_InData`, `eng_OPMode`, `eng_dReadReg`, `eng_dWriteReg` = 0; `eng_bCE`, `eng_bWE`, `eng_bOPEnable` = 1.
- Reset wins over every state. Reset mid-operation abandons it with no `done`, and the engine pins return to idle on the next edge.
- Planes per mode (P): Gaussian X (P=1); Sobel X (P=1); NMS X then Y (P=2); Hysteresis X, Y, Z (P=3).
- Planes are loaded in that order, raster order within each plane (row 0..4, col 0..4), 25 pixels per plane.
- States and transitions:
  - IDLE: on `start` with mode ≤ 3, latch mode and go to LOAD. With mode ≥ 4, go to ERR.
  - LOAD: one `src_req` per cycle for c1..c25P. Each fetched word is written to the engine one cycle later: `eng_bCE`=0, `eng_bWE`=0, row/col delayed to match, `eng_dWriteReg` = plane. Last write lands at c25P+1.
  - CLEAR (1 cycle): `eng_bCE`=1, `eng_bWE`=1, `eng_bOPEnable`=1. This resets the engine's internal phase.
  - EXEC (N cycles = mode's *_CYC): `eng_bOPEnable`=0, `eng_bCE`=1, `eng_OPMode` = mode; a counter runs N-1 down to 0.
  - READ (1 cycle): `eng_bCE`=0, `eng_bWE`=1, `eng_bOPEnable`=1, `eng_dReadReg` per mode. NMS reads with row=1, col=1; other modes drive row/col = 0.
  - CAPTURE (1 cycle): `result` <= `eng_OutData`, `result_valid`=1, `result_sel` = read code. In Sobel mode, after the gradient beat go to READ again with code 2 (direction); otherwise go to DONE.
  - DONE: `done`=1 coincides with the final CAPTURE cycle, then return to IDLE.
  - ERR: `done`=1 and `err`=1 on the cycle after accept, no `result_valid`, then return to IDLE.
- Latency: the start-accept edge is c0. Single-beat modes give result_valid/done at c25P+N+4.
  - Gaussian: c32.
  - NMS: c57.
  - Hysteresis: c82.
  - Sobel: gradient beat at c34; direction beat plus `done` at c36.
- `start` is ignored while `busy`=1. A new `start` is accepted in the IDLE cycle right after `done`.
- Only one of engine write, read or op is active per cycle. `eng_bOPEnable`=1 whenever `eng_bCE`=0.

Optional Feature:
- Macro CANNY_SEQ_PERF_EN.
- When defined: add output port `perf_cycles` (16 bits). It clears to 0 on start-accept, increments each busy cycle, saturates at 0xFFFF, and holds after `done` until the next accept.
- When not defined: the port is still present but tied to 0, and no counter logic is built.

Test Plan:
- Gaussian, all X pixels = 128 → `src_req` seen for c1..c25; `result_valid`/`done` at c32, `result`=128, `result_sel`=0.
- NMS, Y all 0, X(1,1)=50, X(1,0)=20, X(1,2)=30, other X = 0 → `result`=50, `result_sel`=3, `done` at c57.
- Hysteresis, X(1,1)=20, Y all 0, Z all 0 → `result`=1, `result_sel`=4 at c82. Repeat with X(1,1)=5 → `result`=0.
- Sobel, any data → exactly two `result_valid` beats, at c34 (`sel`=1) and c36 (`sel`=2); `done` only at c36; CLEAR then 5 cycles of `eng_bOPEnable`=0.
- `start` pulsed at c10 during Gaussian, and `mode`=6 start from IDLE → first start ignored and the op completes normally; the invalid start gives `done`=1, `err`=1 one cycle after accept, with no `result_valid`.
- `rst` asserted at c12 of a Hysteresis load → next cycle `busy`=0, `eng_bCE`=`eng_bWE`=`eng_bOPEnable`=1, no `done`; a fresh Gaussian start then completes at c32.
